// File: rtl/icache_fill_ctrl_r32i_if.sv
// Bus bundle between the refill controller, the PC/icache arrays and the memory port.
interface icache_fill_ctrl_r32i_if #(
   parameter int unsigned dataW     = 32,
   parameter int unsigned LineWords = 4
);
   localparam int unsigned IdxW = (LineWords > 1) ? $clog2(LineWords) : 1;

   logic [dataW-1:0] ProgAddr;
   logic             CacheHit;
   logic             MemReq;
   logic [dataW-1:0] MemAddr;
   logic             MemAck;
   logic             MemRValid;
   logic [dataW-1:0] MemRData;
   logic             FillWe;
   logic [IdxW-1:0]  FillIndex;
   logic [dataW-1:0] FillData;
   logic [dataW-1:0] FillAddr;
   logic             FillTagWe;
   logic             InsCacheStall;
   logic             FetchErr;

   // Controller side
   modport master (
      input  ProgAddr, CacheHit, MemAck, MemRValid, MemRData,
      output MemReq, MemAddr, FillWe, FillIndex, FillData, FillAddr,
             FillTagWe, InsCacheStall, FetchErr
   );

   // PC / cache / memory side
   modport slave (
      output ProgAddr, CacheHit, MemAck, MemRValid, MemRData,
      input  MemReq, MemAddr, FillWe, FillIndex, FillData, FillAddr,
             FillTagWe, InsCacheStall, FetchErr
   );
endinterface

// File: rtl/icache_fill_ctrl_r32i.sv
// Instruction-cache refill controller: on a miss, stall the PC, burst-read one
// aligned line, write it into the data array, then commit the tag/valid entry.
module icache_fill_ctrl_r32i #(
   parameter int unsigned dataW         = 32,
   parameter int unsigned LineWords     = 4,
   parameter int unsigned TimeoutCycles = 255
) (
   input logic                    clock,
   input logic                    reset,
   icache_fill_ctrl_r32i_if.master bus
);
   localparam int unsigned IdxW = (LineWords > 1) ? $clog2(LineWords) : 1;
   localparam int unsigned OffW = IdxW + 2;
   localparam int unsigned TmrW = 8;
   localparam logic [dataW-1:0] OFF_MASK = dataW'((1 << OffW) - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REQ    = 3'd1,
      FILL   = 3'd2,
      COMMIT = 3'd3,
      ERROR  = 3'd4
   } state_t;

   state_t           r_state,     w_state_nxt;
   logic [IdxW-1:0]  r_beat,      w_beat_nxt;
   logic [TmrW-1:0]  r_timer,     w_timer_nxt;
   logic [dataW-1:0] r_line_base, w_line_base_nxt;
   logic [TmrW-1:0]  w_timer_inc;
   logic             w_timeout;

   // State and datapath registers with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= IDLE;
         r_beat      <= '0;
         r_timer     <= '0;
         r_line_base <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_beat      <= w_beat_nxt;
         r_timer     <= w_timer_nxt;
         r_line_base <= w_line_base_nxt;
      end
   end

   // Next-state, beat counter, idle-cycle timer and line-base capture
   always_comb begin
      w_state_nxt     = r_state;
      w_beat_nxt      = r_beat;
      w_timer_nxt     = r_timer;
      w_line_base_nxt = r_line_base;
      w_timer_inc     = r_timer + TmrW'(1);
      w_timeout       = (w_timer_inc == TmrW'(TimeoutCycles));
      case (r_state)
         IDLE: begin
            if (!bus.CacheHit) begin
               w_line_base_nxt = bus.ProgAddr & ~OFF_MASK;
               w_beat_nxt      = '0;
               w_timer_nxt     = '0;
               w_state_nxt     = REQ;
            end
         end
         REQ: begin
            // A beat coincident with the ack is dropped; only the ack counts.
            if (bus.MemAck) begin
               w_beat_nxt  = '0;
               w_timer_nxt = '0;
               w_state_nxt = FILL;
            end else if (w_timeout) begin
               w_state_nxt = ERROR;
            end else begin
               w_timer_nxt = w_timer_inc;
            end
         end
         FILL: begin
            if (bus.MemRValid) begin
               w_beat_nxt  = r_beat + IdxW'(1);
               w_timer_nxt = '0;
               if (r_beat == IdxW'(LineWords - 1)) begin
                  w_beat_nxt  = '0;
                  w_state_nxt = COMMIT;
               end
            end else if (w_timeout) begin
               w_state_nxt = ERROR;
            end else begin
               w_timer_nxt = w_timer_inc;
            end
         end
         COMMIT:  w_state_nxt = IDLE;
         ERROR:   w_state_nxt = ERROR;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Output decode from state (stall in IDLE and fill strobes follow inputs)
   always_comb begin
      bus.MemReq        = 1'b0;
      bus.FillWe        = 1'b0;
      bus.FillIndex     = '0;
      bus.FillData      = '0;
      bus.FillTagWe     = 1'b0;
      bus.InsCacheStall = 1'b0;
      bus.FetchErr      = 1'b0;
      bus.MemAddr       = r_line_base;
      bus.FillAddr      = r_line_base;
      case (r_state)
         IDLE: bus.InsCacheStall = !bus.CacheHit;
         REQ: begin
            bus.MemReq        = 1'b1;
            bus.InsCacheStall = 1'b1;
         end
         FILL: begin
            bus.InsCacheStall = 1'b1;
            if (bus.MemRValid) begin
               bus.FillWe    = 1'b1;
               bus.FillIndex = r_beat;
               bus.FillData  = bus.MemRData;
            end
         end
         COMMIT: begin
            bus.FillTagWe     = 1'b1;
            bus.InsCacheStall = 1'b1;
         end
         ERROR: begin
            bus.InsCacheStall = 1'b1;
            bus.FetchErr      = 1'b1;
         end
         default: bus.InsCacheStall = 1'b1;
      endcase
   end
endmodule
